// File: rtl/tl_fc_credit_gate.sv
// Transmit-side flow-control credit gate: tracks CL/CC for P/NP/CPL header and
// data credits and admits a TLP only when modulo-arithmetic credit checks pass.
module tl_fc_credit_gate #(
   parameter int HDR_W = 8,
   parameter int DAT_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_valid,
   input  logic [3*HDR_W-1:0] init_hdr,
   input  logic [3*DAT_W-1:0] init_dat,
   input  logic               upd_valid,
   input  logic [1:0]         upd_type,
   input  logic [HDR_W-1:0]   upd_hdr,
   input  logic [DAT_W-1:0]   upd_dat,
   input  logic               req_valid,
   input  logic [1:0]         req_type,
   input  logic [9:0]         req_len,
   input  logic               req_has_data,
   output logic               req_ready,
   output logic               fc_ready,
   output logic [3*HDR_W-1:0] avail_hdr,
   output logic [3*DAT_W-1:0] avail_dat,
   output logic               fc_err
);

   localparam int NCLS = 3;
   localparam logic [HDR_W-1:0] HDR_HALF = {1'b1, {(HDR_W-1){1'b0}}};
   localparam logic [DAT_W-1:0] DAT_HALF = {1'b1, {(DAT_W-1){1'b0}}};

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                     state_q, state_d;
   logic [NCLS-1:0][HDR_W-1:0] cl_hdr_q, cl_hdr_d, cc_hdr_q, cc_hdr_d;
   logic [NCLS-1:0][DAT_W-1:0] cl_dat_q, cl_dat_d, cc_dat_q, cc_dat_d;
   logic [NCLS-1:0][HDR_W-1:0] avail_hdr_q, avail_hdr_d;
   logic [NCLS-1:0][DAT_W-1:0] avail_dat_q, avail_dat_d;
   logic [NCLS-1:0]            inf_hdr_q, inf_hdr_d, inf_dat_q, inf_dat_d;
   logic                       fc_err_q, fc_err_d;
   logic [NCLS-1:0]            hdr_pass, dat_pass;
   logic [10:0]                len_dw;
   logic [8:0]                 need9;
   logic [DAT_W-1:0]           need_dat;
   logic                       sel_ok, fire;

   // A zero length field means a full 1024 DW payload; data credits are 4 DW each.
   assign len_dw   = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
   assign need9    = 9'((len_dw + 11'd3) >> 2);
   assign need_dat = req_has_data ? DAT_W'(need9) : '0;

   for (genvar k = 0; k < NCLS; k++) begin : g_chk
      logic [HDR_W-1:0] hdr_rem;
      logic [DAT_W-1:0] dat_rem;
      assign hdr_rem     = cl_hdr_q[k] - (cc_hdr_q[k] + HDR_W'(1));
      assign dat_rem     = cl_dat_q[k] - (cc_dat_q[k] + need_dat);
      assign hdr_pass[k] = inf_hdr_q[k] || (hdr_rem <= HDR_HALF);
      assign dat_pass[k] = inf_dat_q[k] || (need_dat == '0) || (dat_rem <= DAT_HALF);
   end

   always_comb begin
      sel_ok = 1'b0;
      for (int k = 0; k < NCLS; k++) begin
         if (req_type == 2'(k)) sel_ok = hdr_pass[k] && dat_pass[k];
      end
   end

   assign req_ready = (state_q == ACTIVE) && sel_ok;
   assign fire      = req_valid && req_ready;

   always_comb begin
      logic [HDR_W-1:0] hdr_new;
      logic [DAT_W-1:0] dat_new;
      logic             err;
      state_d   = state_q;
      cl_hdr_d  = cl_hdr_q;
      cc_hdr_d  = cc_hdr_q;
      cl_dat_d  = cl_dat_q;
      cc_dat_d  = cc_dat_q;
      inf_hdr_d = inf_hdr_q;
      inf_dat_d = inf_dat_q;
      fc_err_d  = fc_err_q;
      hdr_new   = '0;
      dat_new   = '0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_valid) begin
               state_d = ACTIVE;
               for (int k = 0; k < NCLS; k++) begin
                  cl_hdr_d[k]  = init_hdr[k*HDR_W +: HDR_W];
                  cl_dat_d[k]  = init_dat[k*DAT_W +: DAT_W];
                  cc_hdr_d[k]  = '0;
                  cc_dat_d[k]  = '0;
                  inf_hdr_d[k] = (init_hdr[k*HDR_W +: HDR_W] == '0);
                  inf_dat_d[k] = (init_dat[k*DAT_W +: DAT_W] == '0);
               end
            end
         end
         ACTIVE: begin
            for (int k = 0; k < NCLS; k++) begin
               if (fire && req_type == 2'(k)) begin
                  if (!inf_hdr_q[k]) cc_hdr_d[k] = cc_hdr_q[k] + HDR_W'(1);
                  if (!inf_dat_q[k]) cc_dat_d[k] = cc_dat_q[k] + need_dat;
               end
               // Error check uses the post-fire CC so a same-cycle grant is accounted for.
               if (upd_valid && upd_type == 2'(k)) begin
                  if (!inf_hdr_q[k]) begin
                     cl_hdr_d[k] = upd_hdr;
                     hdr_new     = upd_hdr - cc_hdr_d[k];
                     if (hdr_new > HDR_HALF) err = 1'b1;
                  end
                  if (!inf_dat_q[k]) begin
                     cl_dat_d[k] = upd_dat;
                     dat_new     = upd_dat - cc_dat_d[k];
                     if (dat_new > DAT_HALF) err = 1'b1;
                  end
               end
            end
            fc_err_d = fc_err_q | err;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NCLS; k++) begin
         avail_hdr_d[k] = inf_hdr_d[k] ? '1 : cl_hdr_d[k] - cc_hdr_d[k];
         avail_dat_d[k] = inf_dat_d[k] ? '1 : cl_dat_d[k] - cc_dat_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cl_hdr_q    <= '0;
         cc_hdr_q    <= '0;
         cl_dat_q    <= '0;
         cc_dat_q    <= '0;
         inf_hdr_q   <= '0;
         inf_dat_q   <= '0;
         avail_hdr_q <= '0;
         avail_dat_q <= '0;
         fc_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cl_hdr_q    <= cl_hdr_d;
         cc_hdr_q    <= cc_hdr_d;
         cl_dat_q    <= cl_dat_d;
         cc_dat_q    <= cc_dat_d;
         inf_hdr_q   <= inf_hdr_d;
         inf_dat_q   <= inf_dat_d;
         avail_hdr_q <= avail_hdr_d;
         avail_dat_q <= avail_dat_d;
         fc_err_q    <= fc_err_d;
      end
   end

   assign fc_ready  = (state_q == ACTIVE);
   assign avail_hdr = avail_hdr_q;
   assign avail_dat = avail_dat_q;
   assign fc_err    = fc_err_q;

endmodule

// File: tb/tb_tl_fc_credit_gate.sv
// Scenario-driven bench for tl_fc_credit_gate; expected available-credit values
// are queued when stimulus is driven and compared once the registers update.
module tb_tl_fc_credit_gate;

   localparam int HW = 8;
   localparam int DW = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic            init_valid;
   logic [3*HW-1:0] init_hdr;
   logic [3*DW-1:0] init_dat;
   logic            upd_valid;
   logic [1:0]      upd_type;
   logic [HW-1:0]   upd_hdr;
   logic [DW-1:0]   upd_dat;
   logic            req_valid;
   logic [1:0]      req_type;
   logic [9:0]      req_len;
   logic            req_has_data;
   logic            req_ready;
   logic            fc_ready;
   logic [3*HW-1:0] avail_hdr;
   logic [3*DW-1:0] avail_dat;
   logic            fc_err;

   typedef struct {
      string         name;
      int            cls;
      logic [HW-1:0] hdr;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_fail = 0;

   tl_fc_credit_gate #(.HDR_W(HW), .DAT_W(DW)) dut (
      .clk(clk), .rst(rst),
      .init_valid(init_valid), .init_hdr(init_hdr), .init_dat(init_dat),
      .upd_valid(upd_valid), .upd_type(upd_type), .upd_hdr(upd_hdr), .upd_dat(upd_dat),
      .req_valid(req_valid), .req_type(req_type), .req_len(req_len), .req_has_data(req_has_data),
      .req_ready(req_ready), .fc_ready(fc_ready),
      .avail_hdr(avail_hdr), .avail_dat(avail_dat), .fc_err(fc_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [HW-1:0] ah(input int k);
      return avail_hdr[k*HW +: HW];
   endfunction

   function automatic logic [DW-1:0] ad(input int k);
      return avail_dat[k*DW +: DW];
   endfunction

   task automatic push(input string n, input int k, input logic [HW-1:0] h, input logic [DW-1:0] d);
      exp_t x;
      x.name = n; x.cls = k; x.hdr = h; x.dat = d;
      sb.push_back(x);
   endtask

   task automatic set_req(input logic v, input logic [1:0] t, input logic [9:0] len, input logic d);
      req_valid = v; req_type = t; req_len = len; req_has_data = d;
   endtask

   task automatic fire_until_blocked(input logic [1:0] t, input int max, output int n);
      n = 0;
      set_req(1'b1, t, 10'd5, 1'b0);
      for (int i = 0; i < max; i++) begin
         #1;
         if (!req_ready) break;
         n++;
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; init_valid = 1'b0; init_hdr = '0; init_dat = '0;
      upd_valid = 1'b0; upd_type = 2'd0; upd_hdr = '0; upd_dat = '0;
      set_req(1'b1, 2'd0, 10'd4, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if (fc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_fc_ready: got %b want 0", fc_ready); end
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      n_chk++; if (avail_hdr !== '0 || avail_dat !== '0) begin n_fail++; $display("FAIL rst_avail: got %h/%h want 0/0", avail_hdr, avail_dat); end
      n_chk++; if (fc_err !== 1'b0) begin n_fail++; $display("FAIL rst_fc_err: got %b want 0", fc_err); end
      @(negedge clk);
      rst = 1'b0;
      // update while still uninitialised must be dropped
      upd_valid = 1'b1; upd_type = 2'd0; upd_hdr = 8'd50; upd_dat = 12'd50;
      @(negedge clk);
      upd_valid = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic test_init_grant;
      init_valid = 1'b1;
      init_hdr = {8'd0, 8'd120, 8'd2};
      init_dat = {12'd0, 12'd0, 12'd8};
      set_req(1'b0, 2'd0, 10'd16, 1'b1);
      #1;
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", req_ready); end
      push("init_p", 0, 8'd2, 12'd8);
      push("init_np", 1, 8'd120, 12'hFFF);
      push("init_cpl", 2, 8'hFF, 12'hFFF);
      @(negedge clk);
      init_valid = 1'b0;
      n_chk++; if (fc_ready !== 1'b1) begin n_fail++; $display("FAIL init_fc_ready: got %b want 1", fc_ready); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
      req_valid = 1'b1;
      #1;
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL first_grant: got %b want 1", req_ready); end
      push("first_fire", 0, 8'd1, 12'd4);
      @(negedge clk);
      req_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
   endtask

   task automatic test_exhaust_update;
      set_req(1'b1, 2'd0, 10'd16, 1'b1);
      #1;
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL last_credit: got %b want 1", req_ready); end
      push("exhausted", 0, 8'd0, 12'd0);
      @(negedge clk);
      set_req(1'b1, 2'd0, 10'd4, 1'b1);
      #1;
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_block: got %b want 0", req_ready); end
      req_type = 2'd3;
      #1;
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL type3_block: got %b want 0", req_ready); end
      req_type = 2'd0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
      @(negedge clk);
      upd_valid = 1'b1; upd_type = 2'd0; upd_hdr = 8'd4; upd_dat = 12'd16;
      #1;
      n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL upd_same_cycle: got %b want 0", req_ready); end
      push("after_upd", 0, 8'd2, 12'd8);
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL upd_next_cycle: got %b want 1", req_ready); end
      req_valid = 1'b0;
      // invalid-type update and a late InitFC are both dropped
      upd_valid = 1'b1; upd_type = 2'd3; upd_hdr = 8'd99; upd_dat = 12'd99;
      init_valid = 1'b1; init_hdr = {3{8'd5}}; init_dat = {3{12'd5}};
      push("ignored_p", 0, 8'd2, 12'd8);
      push("ignored_np", 1, 8'd120, 12'hFFF);
      @(negedge clk);
      upd_valid = 1'b0; init_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
   endtask

   task automatic test_simultaneous;
      // P: CL 4/16, CC 2/8. Fire need 4 and update dat to CC+20 in the same cycle.
      set_req(1'b1, 2'd0, 10'd16, 1'b1);
      upd_valid = 1'b1; upd_type = 2'd0; upd_hdr = 8'd4; upd_dat = 12'd28;
      #1;
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b want 1", req_ready); end
      push("simul", 0, 8'd1, 12'd16);
      @(negedge clk);
      req_valid = 1'b0; upd_valid = 1'b0;
      n_chk++; if (fc_err !== 1'b0) begin n_fail++; $display("FAIL simul_err: got %b want 0", fc_err); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
   endtask

   task automatic test_infinite;
      int bad_rdy = 0;
      int bad_av  = 0;
      set_req(1'b1, 2'd2, 10'd0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         #1;
         n_chk++;
         if (req_ready !== 1'b1) begin
            n_fail++; bad_rdy++;
            if (bad_rdy < 4) $display("FAIL inf_ready[%0d]: got %b want 1", i, req_ready);
         end
         n_chk++;
         if (ah(2) !== 8'hFF || ad(2) !== 12'hFFF) begin
            n_fail++; bad_av++;
            if (bad_av < 4) $display("FAIL inf_avail[%0d]: got %h/%h want ff/fff", i, ah(2), ad(2));
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      push("inf_p_untouched", 0, 8'd1, 12'd16);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
            n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
         end
      end
   endtask

   task automatic test_wrap;
      int n;
      int want [3] = '{120, 128, 12};
      logic [HW-1:0] cl_upd [2] = '{8'd248, 8'd4};
      logic [HW-1:0] av_upd [2] = '{8'd128, 8'd12};
      for (int r = 0; r < 3; r++) begin
         fire_until_blocked(2'd1, 200, n);
         n_chk++; if (n !== want[r]) begin n_fail++; $display("FAIL wrap_grants[%0d]: got %0d want %0d", r, n, want[r]); end
         push("wrap_drained", 1, 8'd0, 12'hFFF);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
               n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
            end
         end
         if (r < 2) begin
            // 248 is exactly half the space ahead of CC=120; 4 is 260 after wrap
            upd_valid = 1'b1; upd_type = 2'd1; upd_hdr = cl_upd[r]; upd_dat = 12'd7;
            push("wrap_upd", 1, av_upd[r], 12'hFFF);
            @(negedge clk);
            upd_valid = 1'b0;
            n_chk++; if (fc_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err[%0d]: got %b want 0", r, fc_err); end
            while (sb.size() > 0) begin
               e = sb.pop_front();
               n_chk++;
               if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
                  n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
               end
            end
         end
      end
   endtask

   task automatic test_error_reset;
      // P dat CC = 12: 2060 leaves exactly 2048 (legal), 2061 leaves 2049 (error)
      logic [DW-1:0] cl [2]  = '{12'd2060, 12'd2061};
      logic          ex [2]  = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         upd_valid = 1'b1; upd_type = 2'd0; upd_hdr = 8'd4; upd_dat = cl[i];
         push("err_upd", 0, 8'd1, cl[i] - 12'd12);
         @(negedge clk);
         upd_valid = 1'b0;
         n_chk++; if (fc_err !== ex[i]) begin n_fail++; $display("FAIL err_flag[%0d]: got %b want %b", i, fc_err, ex[i]); end
         while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (ah(e.cls) !== e.hdr || ad(e.cls) !== e.dat) begin
               n_fail++; $display("FAIL %s: avail got %0d/%0d want %0d/%0d", e.name, ah(e.cls), ad(e.cls), e.hdr, e.dat);
            end
         end
      end
      repeat (3) @(negedge clk);
      n_chk++; if (fc_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", fc_err); end
      set_req(1'b1, 2'd0, 10'd4, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_chk++; if (fc_ready !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b/%b want 0/0", fc_ready, req_ready); end
      n_chk++; if (avail_hdr !== '0 || avail_dat !== '0) begin n_fail++; $display("FAIL midrst_avail: got %h/%h want 0/0", avail_hdr, avail_dat); end
      n_chk++; if (fc_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", fc_err); end
      rst = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_init_grant;
      test_exhaust_update;
      test_simultaneous;
      test_infinite;
      test_wrap;
      test_error_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
